// File: rtl/hdmi_link_ctrl.sv
// HDMI/DVI output bring-up controller: sequences DVI encoder reset from MMCM lock and
// hot-plug, qualifies the first frame, and applies button-driven pattern changes at frame start.
module hdmi_link_ctrl #(
    parameter int HPD_DEBOUNCE   = 74250,
    parameter int BTN_DEBOUNCE   = 742500,
    parameter int DVI_RST_CYCLES = 16,
    parameter int NUM_PATTERNS   = 4
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic        mmcm_locked,
    input  logic        hdmi_hdp,
    input  logic        btn,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    output logic        dvi_rst,
    output logic        link_up,
    output logic [1:0]  pattern_sel,
    output logic [15:0] frame_cnt,
    output logic [2:0]  state
);

    localparam int HPD_CW = $clog2(HPD_DEBOUNCE + 1);
    localparam int BTN_CW = $clog2(BTN_DEBOUNCE + 1);
    localparam int RST_CW = $clog2(DVI_RST_CYCLES + 1);
    localparam logic [HPD_CW-1:0] HPD_LAST = HPD_CW'(HPD_DEBOUNCE - 1);
    localparam logic [BTN_CW-1:0] BTN_LAST = BTN_CW'(BTN_DEBOUNCE - 1);
    localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(DVI_RST_CYCLES - 1);
    localparam logic [1:0]        PAT_LAST = 2'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        WAIT_HPD   = 3'd1,
        RESET_DVI  = 3'd2,
        WAIT_FRAME = 3'd3,
        ACTIVE     = 3'd4
    } state_t;

    state_t            st;
    logic [RST_CW-1:0] st_cnt;
    logic              lock_p0, lock_p1, hpd_p0, hpd_p1, btn_p0, btn_p1;
    logic [HPD_CW-1:0] hpd_cnt;
    logic [BTN_CW-1:0] btn_cnt;
    logic              hpd_deb, btn_deb, btn_deb_d, pend;
    logic              fs, btn_rise;

    assign state    = st;
    assign fs       = (cx == 10'd0) && (cy == 10'd0) && !dvi_rst;
    assign btn_rise = btn_deb && !btn_deb_d;

    // Two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            {lock_p0, lock_p1, hpd_p0, hpd_p1, btn_p0, btn_p1} <= 6'b0;
        end else begin
            lock_p0 <= mmcm_locked;
            lock_p1 <= lock_p0;
            hpd_p0  <= hdmi_hdp;
            hpd_p1  <= hpd_p0;
            btn_p0  <= btn;
            btn_p1  <= btn_p0;
        end
    end

    // Debounce: the counter only runs while the input disagrees with the debounced value
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            hpd_cnt   <= '0;
            btn_cnt   <= '0;
            hpd_deb   <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_d <= 1'b0;
        end else begin
            btn_deb_d <= btn_deb;
            if (hpd_p1 == hpd_deb) begin
                hpd_cnt <= '0;
            end else if (hpd_cnt == HPD_LAST) begin
                hpd_deb <= hpd_p1;
                hpd_cnt <= '0;
            end else begin
                hpd_cnt <= hpd_cnt + HPD_CW'(1);
            end
            if (btn_p1 == btn_deb) begin
                btn_cnt <= '0;
            end else if (btn_cnt == BTN_LAST) begin
                btn_deb <= btn_p1;
                btn_cnt <= '0;
            end else begin
                btn_cnt <= btn_cnt + BTN_CW'(1);
            end
        end
    end

    // Link state machine; outputs are registered alongside the state they belong to
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            st          <= WAIT_LOCK;
            st_cnt      <= '0;
            dvi_rst     <= 1'b1;
            link_up     <= 1'b0;
            pattern_sel <= 2'd0;
            frame_cnt   <= 16'd0;
            pend        <= 1'b0;
        end else if (!lock_p1) begin
            st      <= WAIT_LOCK;
            dvi_rst <= 1'b1;
            link_up <= 1'b0;
            pend    <= 1'b0;
        end else if (!hpd_deb && (st == RESET_DVI || st == WAIT_FRAME || st == ACTIVE)) begin
            st      <= WAIT_HPD;
            dvi_rst <= 1'b1;
            link_up <= 1'b0;
            pend    <= 1'b0;
        end else begin
            case (st)
                WAIT_LOCK: st <= WAIT_HPD;
                WAIT_HPD: begin
                    if (hpd_deb) begin
                        st     <= RESET_DVI;
                        st_cnt <= '0;
                    end
                end
                RESET_DVI: begin
                    if (st_cnt == RST_LAST) begin
                        st      <= WAIT_FRAME;
                        dvi_rst <= 1'b0;
                    end else begin
                        st_cnt <= st_cnt + RST_CW'(1);
                    end
                end
                WAIT_FRAME: begin
                    if (fs) begin
                        st        <= ACTIVE;
                        link_up   <= 1'b1;
                        frame_cnt <= 16'd0;
                        pend      <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (fs) frame_cnt <= frame_cnt + 16'd1;
                    // A press landing on the advancing frame start merges into that advance
                    if (fs && pend) begin
                        pattern_sel <= (pattern_sel == PAT_LAST) ? 2'd0 : pattern_sel + 2'd1;
                        pend        <= 1'b0;
                    end else if (btn_rise) begin
                        pend <= 1'b1;
                    end
                end
                default: begin
                    st      <= WAIT_LOCK;
                    dvi_rst <= 1'b1;
                    link_up <= 1'b0;
                    pend    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hdmi_link_ctrl.md
# hdmi_link_ctrl

Bring-up and run-time controller for the HDMI/DVI output path, clocked on the pixel clock. It holds the DVI encoder in reset until the MMCM is locked and a sink is attached, then releases it. It qualifies the first frame boundary before declaring the link up, and schedules test-pattern changes from the front-panel button so they only take effect at a frame start. It sits between the clock/IO top level and the DVI encoder plus pattern generator.

## Interface
- `HPD_DEBOUNCE`, default 74250: cycles `hdmi_hdp` must be stable before its debounced value changes (1 ms at 74.25 MHz).
- `BTN_DEBOUNCE`, default 742500: cycles `btn` must be stable before its debounced value changes (10 ms).
- `DVI_RST_CYCLES`, default 16: cycles `dvi_rst` is held high in RESET_DVI.
- `NUM_PATTERNS`, default 4: number of selectable patterns, 2..4.
- `clk_pixel`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `mmcm_locked`, in, 1: MMCM lock, asynchronous.
- `hdmi_hdp`, in, 1: hot-plug detect, asynchronous, high = sink present.
- `btn`, in, 1: pattern-advance button, asynchronous, active-high.
- `cx`, in, 10: current pixel x from the DVI encoder.
- `cy`, in, 10: current pixel y from the DVI encoder.
- `dvi_rst`, out, 1: synchronous reset to the DVI encoder.
- `link_up`, out, 1: high in ACTIVE only.
- `pattern_sel`, out, 2: selected test pattern.
- `frame_cnt`, out, 16: frames emitted since entering ACTIVE.
- `state`, out, 3: current state encoding, for LEDs.

## Operation
- **Input synchronisers:**
  - `mmcm_locked`, `hdmi_hdp` and `btn` each pass through a 2-flop synchroniser.
  - The synchroniser flops reset to 0.
- **Debounce:**
  - Each of hpd and btn has a counter that restarts whenever the synchronised input differs from its debounced value.
  - When the counter reaches DEBOUNCE-1 with the input still different, the debounced value takes the input value. The counter is cleared.
  - Debounced values reset to 0.
- **Frame start (`fs`):** `cx==0 && cy==0`, sampled while `dvi_rst` is low.
- **State machine,** encodings 0..4:
  - **WAIT_LOCK:**
    - `dvi_rst=1`.
    - Go to WAIT_HPD when synchronised lock is 1.
  - **WAIT_HPD:**
    - `dvi_rst=1`.
    - Go to RESET_DVI when debounced hpd is 1.
  - **RESET_DVI:**
    - `dvi_rst=1` for exactly DVI_RST_CYCLES cycles, counted by the state counter.
    - Then go to WAIT_FRAME.
  - **WAIT_FRAME:**
    - `dvi_rst=0`.
    - Go to ACTIVE on the first `fs`.
  - **ACTIVE:**
    - `dvi_rst=0`, `link_up=1`.
- **Fault transitions:**
  - Synchronised lock = 0 in any state goes to WAIT_LOCK. This has highest priority.
  - Debounced hpd = 0 in RESET_DVI, WAIT_FRAME or ACTIVE goes to WAIT_HPD.
- **`frame_cnt`:**
  - Cleared on entering ACTIVE.
  - Increments on each `fs` in ACTIVE, except the cycle of entry.
  - Wraps from 0xFFFF to 0.
- **Pattern scheduling:**
  - A debounced btn rising edge sets `pend`.
  - At the next `fs` in ACTIVE with `pend` set, `pattern_sel` advances to `(pattern_sel+1) mod NUM_PATTERNS` and `pend` clears.
  - A btn edge on the same cycle as that `fs` is consumed by it; `pend` stays 0.
  - Edges arriving while `pend` is already set are merged, so at most one advance happens per frame.
  - Outside ACTIVE, `pend` is cleared and btn edges are ignored.
  - `pattern_sel` is preserved across link drops and cleared only by `rst`.

## Timing
- **Reset values:**
  - `dvi_rst=1`, `link_up=0`, `pattern_sel=0`, `frame_cnt=0`, `state=0` (WAIT_LOCK).
  - `pend=0`, debounce counters and debounced values 0.
- **Latencies:**
  - Lock: input edge to state change takes 3 cycles (2 synchroniser cycles plus 1 register).
  - hpd: 2 + HPD_DEBOUNCE + 1 cycles.
- **Registered outputs:**
  - All outputs are registered and change the cycle after the state transition.
  - `pattern_sel` and `frame_cnt` update the cycle after `fs`, i.e. valid during pixel (1,0).
- **`rst` mid-operation:** all registers return to their reset values on the next edge. `dvi_rst` rises in that same cycle.

## Test plan
- **Bring-up:**
  - Stimulus: `rst` for 4 cycles; lock=1 at t0; hpd=1; HPD_DEBOUNCE=8; DVI_RST_CYCLES=4.
  - Required: `dvi_rst` falls after 4 cycles in RESET_DVI; `link_up` rises 1 cycle after the first `cx=cy=0`; `frame_cnt=0`.
- **Frame count:**
  - Stimulus: 3 further frames (cx/cy sweeping a 4x3 frame).
  - Required: `frame_cnt` = 1, 2, 3.
  - Also force `frame_cnt` to 0xFFFF and apply one more `fs`: required `frame_cnt=0`.
- **Pattern advance:**
  - Stimulus: BTN_DEBOUNCE=8; a press mid-frame; then 3 presses within one frame.
  - Required: `pattern_sel` goes 0→1 at the next `fs`; the 3 presses give exactly one advance.
  - With NUM_PATTERNS=4, 4 advances give 0.
- **Bounce rejection:**
  - Stimulus: btn and hpd toggling every 3 cycles with DEBOUNCE=8.
  - Required: no pattern change and no state change.
- **Hot-unplug:**
  - Stimulus: hpd=0 held ≥10 cycles while ACTIVE.
  - Required: state=WAIT_HPD, `dvi_rst=1`, `link_up=0`, `pattern_sel` retained.
  - Replug: returns to ACTIVE with `frame_cnt` cleared.
- **Lock loss priority:**
  - Stimulus: drop lock in ACTIVE on the same cycle as an hpd fall; separately, assert `rst` in WAIT_FRAME.
  - Required: the first goes to WAIT_LOCK in 3 cycles; the second gives all reset values on the next edge.
